// File: rtl/sm_run_ctrl_pkg.sv
// sm_run_ctrl_pkg: shared types and constants for the run/halt/step sequencer.
//   state_t        : FSM encoding, also driven straight onto the state output port
//   DEF_DEBOUNCE_W : default debounce counter width
//   DEF_CNT_W      : default cpu_en pulse counter width
//   DIV_W          : rate divider width, enough for a terminal count of 2**15-1
//   div_term()     : terminal count 2**sel-1 for a given div_sel
package sm_run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_t;

   localparam int DEF_DEBOUNCE_W = 16;
   localparam int DEF_CNT_W      = 16;
   localparam int DIV_W          = 16;

   function automatic logic [DIV_W-1:0] div_term(input logic [3:0] sel);
      return (DIV_W'(1) << sel) - DIV_W'(1);
   endfunction

endpackage

// File: rtl/sm_debounce.sv
// sm_debounce: one push-button conditioner.
//   A 2-flop synchroniser feeds a stability counter. The debounced level only
//   follows the synchronised key once the key has differed from it for
//   2**W-1 consecutive cycles. A rising edge of the debounced level produces
//   a one-cycle press event.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (debounced level cleared to 0)
//   key  in  raw button, active-high
//   evt  out one-cycle press pulse
module sm_debounce #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic evt
);

   // Counter value on the last cycle of the stable window; the flip happens
   // on that cycle, giving 2**W-1 observed cycles in total.
   localparam logic [W-1:0] LAST = W'((1 << W) - 2);

   logic         sync1, sync2;
   logic         level, level_d;
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= key;
         sync2   <= sync1;
         level_d <= level;
         // Any return to the current level restarts the stability window.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + W'(1);
         end
      end
   end

   assign evt = level & ~level_d;

endmodule

// File: rtl/sm_run_ctrl.sv
// sm_run_ctrl: run/halt/single-step sequencer pacing sm_cpu.
//   Two debounced buttons drive a HALT/RUN/STEP FSM. In RUN a divider issues
//   one registered cpu_en pulse every 2**div_sel cycles; in HALT a step press
//   issues exactly one pulse. cycle_cnt counts every pulse issued.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   key_run        raw button, press toggles RUN/HALT
//   key_step       raw button, press in HALT issues one cpu_en
//   div_sel[3:0]   RUN rate select
//   cpu_en         one-cycle enable pulse to the CPU
//   state[1:0]     00 HALT, 01 RUN, 10 STEP
//   cycle_cnt      pulses issued, wraps
// Optional feature, macro SM_RUN_CTRL_BREAK_EN:
//   bp_en, bp_addr[31:0], pc[31:0] in; bp_hit out. At a RUN terminal count
//   with bp_en and pc==bp_addr the pulse is withheld and the FSM halts.
module sm_run_ctrl
   import sm_run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_W = DEF_DEBOUNCE_W,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_run,
   input  logic             key_step,
   input  logic [3:0]       div_sel,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
`ifdef SM_RUN_CTRL_BREAK_EN
   ,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   input  logic [31:0]      pc,
   output logic             bp_hit
`endif
);

   state_t           cur, nxt;
   logic [DIV_W-1:0] div_cnt, div_nxt;
   logic             en_q, en_nxt;
   logic [CNT_W-1:0] cyc_q;
   logic             run_evt, step_evt;
   logic             brk;

   sm_debounce #(.W(DEBOUNCE_W)) u_db_run (
      .clk (clk),
      .rst (rst),
      .key (key_run),
      .evt (run_evt)
   );

   sm_debounce #(.W(DEBOUNCE_W)) u_db_step (
      .clk (clk),
      .rst (rst),
      .key (key_step),
      .evt (step_evt)
   );

`ifdef SM_RUN_CTRL_BREAK_EN
   // armed is low until the first terminal count after leaving HALT, so a
   // resume from a breakpoint steps past the matching pc.
   logic armed, armed_nxt;
   logic hit_q, hit_nxt;

   assign brk = bp_en && (pc == bp_addr) && armed;
`else
   assign brk = 1'b0;
`endif

   always_comb begin
      nxt     = cur;
      div_nxt = div_cnt;
      en_nxt  = 1'b0;
`ifdef SM_RUN_CTRL_BREAK_EN
      armed_nxt = armed;
      hit_nxt   = hit_q & ~(run_evt | step_evt);
`endif
      case (cur)
         ST_HALT: begin
            if (run_evt) begin
               nxt     = ST_RUN;
               div_nxt = '0;
`ifdef SM_RUN_CTRL_BREAK_EN
               armed_nxt = 1'b0;
`endif
            end else if (step_evt) begin
               // Pulse is registered on entry so cpu_en lines up with STEP.
               nxt    = ST_STEP;
               en_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (run_evt) begin
               nxt     = ST_HALT;
               div_nxt = '0;
            end else if (div_cnt >= div_term(div_sel)) begin
               // >= rather than == so a mid-count drop of div_sel wraps at once.
               div_nxt = '0;
`ifdef SM_RUN_CTRL_BREAK_EN
               armed_nxt = 1'b1;
`endif
               if (brk) begin
                  nxt = ST_HALT;
`ifdef SM_RUN_CTRL_BREAK_EN
                  hit_nxt = 1'b1;
`endif
               end else begin
                  en_nxt = 1'b1;
               end
            end else begin
               div_nxt = div_cnt + DIV_W'(1);
            end
         end
         ST_STEP: nxt = ST_HALT;
         default: nxt = ST_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur     <= ST_HALT;
         div_cnt <= '0;
         en_q    <= 1'b0;
         cyc_q   <= '0;
      end else begin
         cur     <= nxt;
         div_cnt <= div_nxt;
         en_q    <= en_nxt;
         if (en_nxt) cyc_q <= cyc_q + CNT_W'(1);
      end
   end

`ifdef SM_RUN_CTRL_BREAK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0;
         hit_q <= 1'b0;
      end else begin
         armed <= armed_nxt;
         hit_q <= hit_nxt;
      end
   end

   assign bp_hit = hit_q;
`endif

   assign cpu_en    = en_q;
   assign state     = cur;
   assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb_sm_run_ctrl: self-checking bench for sm_run_ctrl with DEBOUNCE_W=4.
//   A negedge monitor holds a reference model of the pulse schedule: in RUN a
//   pulse is due once 2**div_sel cycles have elapsed since RUN entry or the
//   previous pulse, STEP always carries a pulse, HALT never does; the pulse
//   total is tracked against cycle_cnt. Scripted sequences and a rate table
//   cover the scenarios, followed by randomized key/rate activity.
module tb_sm_run_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             key_run = 1'b0;
   logic             key_step = 1'b0;
   logic [3:0]       div_sel = 4'd0;
   logic             cpu_en;
   logic [1:0]       state;
   logic [CNT_W-1:0] cycle_cnt;
`ifdef SM_RUN_CTRL_BREAK_EN
   logic             bp_en = 1'b0;
   logic [31:0]      bp_addr = 32'h0;
   logic [31:0]      pc = 32'h0;
   logic             bp_hit;
`endif

   int tests = 0;
   int fails = 0;

   sm_run_ctrl #(.DEBOUNCE_W(4), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_run   (key_run),
      .key_step  (key_step),
      .div_sel   (div_sel),
      .cpu_en    (cpu_en),
      .state     (state),
      .cycle_cnt (cycle_cnt)
`ifdef SM_RUN_CTRL_BREAK_EN
      ,
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .pc        (pc),
      .bp_hit    (bp_hit)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: timed out", nm);
   endtask

   // ---------------- reference model (monitor) ----------------
   int               d_edge = 0;
   int               since = 0;
   logic [1:0]       prev_st = 2'b00;
   logic [CNT_W-1:0] mdl_cnt = '0;
   bit               seen_step = 1'b0;

   always @(posedge clk) d_edge = int'(div_sel);

   always @(negedge clk) begin
      bit exp_en;
      if (rst) begin
         since   = 0;
         mdl_cnt = '0;
         prev_st = 2'b00;
      end else begin
         exp_en = 1'b0;
         case (state)
            2'b01: begin
               if (prev_st != 2'b01) since = 0;
               else begin
                  since++;
                  if (since >= (1 << d_edge)) begin
                     exp_en = 1'b1;
                     since  = 0;
                  end
               end
            end
            2'b10: begin
               exp_en    = 1'b1;
               seen_step = 1'b1;
            end
            default: exp_en = 1'b0;
         endcase
         mdl_cnt = mdl_cnt + CNT_W'(exp_en);
         chk("mon_cpu_en", cpu_en, exp_en);
         chk("mon_cycle_cnt", cycle_cnt, mdl_cnt);
         prev_st = state;
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_state(input logic [1:0] s, input int bound, input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (state != s && n < bound);
      chk(nm, state, s);
   endtask

   task automatic wait_pulse(input int bound, input string nm, output int gap);
      gap = 0;
      do begin
         @(negedge clk);
         gap++;
      end while (!cpu_en && gap < bound);
      if (!cpu_en) timeout(nm);
   endtask

   task automatic press(input bit r, input bit s);
      key_run  = r;
      key_step = s;
      repeat (30) @(negedge clk);
      key_run  = 1'b0;
      key_step = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   typedef struct {
      logic [3:0] d;
      int         period;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int               g;
      bit               exp_run;
      logic [CNT_W-1:0] base;

      tbl[0] = '{4'd0, 1};
      tbl[1] = '{4'd1, 2};
      tbl[2] = '{4'd3, 8};
      tbl[3] = '{4'd5, 32};
      tbl[4] = '{4'd2, 4};

      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      #1 rst = 1'b0;
      repeat (100) @(negedge clk);
      chk("idle_state", state, 0);
      chk("idle_cycle_cnt", cycle_cnt, 0);

      // 2: bouncy run key, div_sel=2, ten pulses
      div_sel = 4'd2;
      repeat (5) begin
         key_run = 1'b1;
         repeat (3) @(negedge clk);
         key_run = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("bounce_no_evt", state, 0);
      key_run = 1'b1;
      wait_state(2'b01, 40, "t2_run");
      for (int i = 0; i < 10; i++) begin
         wait_pulse(20, "t2_pulse", g);
         chk("t2_gap", g, 4);
      end
      chk("t2_cycle_cnt", cycle_cnt, 10);
      key_run = 1'b0;
      repeat (40) @(negedge clk);
      chk("t2_still_run", state, 1);

      // rate table, still in RUN
      foreach (tbl[i]) begin
         div_sel = tbl[i].d;
         wait_pulse(100, "tbl_settle", g);
         for (int k = 0; k < 2; k++) begin
            wait_pulse(100, "tbl_pulse", g);
            chk($sformatf("tbl_period_d%0d", tbl[i].d), g, tbl[i].period);
         end
      end
      press(1'b1, 1'b0);
      chk("halt_after_tbl", state, 0);

      // 3: single step from HALT
      base = mdl_cnt;
      seen_step = 1'b0;
      key_step = 1'b1;
      wait_state(2'b10, 40, "t3_step");
      chk("t3_cpu_en", cpu_en, 1);
      chk("t3_cycle_cnt", cycle_cnt, base + 1);
      @(negedge clk);
      chk("t3_back_halt", state, 0);
      chk("t3_en_low", cpu_en, 0);
      key_step = 1'b0;
      repeat (40) @(negedge clk);
      chk("t3_one_pulse", cycle_cnt, base + 1);

      // 4: div_sel 4 -> 1 at count 9
      div_sel = 4'd4;
      key_run = 1'b1;
      wait_state(2'b01, 40, "t4_run");
      wait_pulse(40, "t4_first", g);
      chk("t4_first_gap", g, 16);
      repeat (9) @(negedge clk);
      div_sel = 4'd1;
      @(negedge clk);
      chk("t4_wrap_pulse", cpu_en, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_every2", cpu_en, k % 2);
      end
      key_run = 1'b0;
      repeat (30) @(negedge clk);
      press(1'b1, 1'b0);
      chk("t4_halt", state, 0);

      // 5: both keys at once in HALT, then run key halts
      div_sel = 4'd15;
      base = mdl_cnt;
      seen_step = 1'b0;
      key_run = 1'b1;
      key_step = 1'b1;
      wait_state(2'b01, 40, "t5_run");
      repeat (30) @(negedge clk);
      chk("t5_no_step", seen_step, 0);
      chk("t5_no_pulse", cycle_cnt, base);
      key_run = 1'b0;
      key_step = 1'b0;
      repeat (30) @(negedge clk);
      press(1'b1, 1'b0);
      chk("t5_halt", state, 0);
      repeat (100) @(negedge clk);
      chk("t5_quiet", cycle_cnt, base);

`ifdef SM_RUN_CTRL_BREAK_EN
      // 6: breakpoint halt and resume past it
      div_sel = 4'd2;
      bp_en = 1'b1;
      bp_addr = 32'h10;
      pc = 32'h0;
      key_run = 1'b1;
      wait_state(2'b01, 40, "t6_run");
      wait_pulse(20, "t6_first", g);
      pc = 32'h10;
      base = mdl_cnt;
      wait_state(2'b00, 20, "t6_bp_halt");
      chk("t6_bp_hit", bp_hit, 1);
      chk("t6_no_pulse", cycle_cnt, base);
      key_run = 1'b0;
      repeat (30) @(negedge clk);
      key_run = 1'b1;
      wait_state(2'b01, 40, "t6_resume");
      chk("t6_bp_clear", bp_hit, 0);
      wait_pulse(10, "t6_past_bp", g);
      chk("t6_past_gap", g, 4);
      wait_state(2'b00, 10, "t6_bp_again");
      chk("t6_bp_hit2", bp_hit, 1);
      key_run = 1'b0;
      bp_en = 1'b0;
      repeat (30) @(negedge clk);
`endif

      // randomized key/rate activity
      exp_run = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         div_sel = 4'($urandom_range(0, 5));
         case ($urandom_range(0, 2))
            0: begin
               press(1'b1, 1'b0);
               exp_run = !exp_run;
            end
            1: press(1'b0, 1'b1);
            default: repeat ($urandom_range(10, 60)) @(negedge clk);
         endcase
         chk("rnd_state", state, exp_run ? 1 : 0);
      end

      // async reset mid-RUN
      div_sel = 4'd0;
      if (!exp_run) press(1'b1, 1'b0);
      repeat (5) @(negedge clk);
      chk("pre_rst_en", cpu_en, 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_state", state, 0);
      chk("arst_cpu_en", cpu_en, 0);
      chk("arst_cycle_cnt", cycle_cnt, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_rst_state", state, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
